// File: rtl/add_serial_seq.sv
// add_serial_seq: operand sequencer in front of the 8-bit serial adder.
// Buffers {a,b} pairs in a small FIFO, launches one addition at a time,
// waits LATENCY cycles for the adder result, then presents it downstream.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   in_valid/in_ready  operand-pair input handshake, operands in_a/in_b
//   add_en             one-cycle start pulse to the adder
//   add_a/add_b        FIFO head operands (0 when FIFO empty)
//   add_out            adder result, sampled LATENCY-1 cycles after add_en
//   res_valid/res_ready/res_sum  result output handshake
//   res_cout           carry-out of head_a+head_b (only with ADD_SEQ_COUT_EN)
//   busy               high whenever the FSM is not in IDLE
//
// Optional feature macro: ADD_SEQ_COUT_EN adds the res_cout port and logic.
module add_serial_seq #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned LATENCY = 10,
  parameter int unsigned DEPTH   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             add_en,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
`ifdef ADD_SEQ_COUT_EN
  output logic             res_cout,
`endif
  output logic             busy
);

  localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned WCW = 8;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_HOLD} state_t;

  state_t           state;
  logic [WCW-1:0]   wcnt;
  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic             push;
  logic             pop;
  logic             empty;
  logic [WIDTH-1:0] head_a;
  logic [WIDTH-1:0] head_b;

  assign push   = in_valid && in_ready;
  assign pop    = res_valid && res_ready;
  assign empty  = (count == '0);
  assign head_a = mem_a[rd_ptr];
  assign head_b = mem_b[rd_ptr];
  assign add_a  = empty ? '0 : head_a;
  assign add_b  = empty ? '0 : head_b;

  // Occupancy update; push and pop together leave the count unchanged.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // FIFO storage and pointers; in_ready is registered from the next count,
  // so a pop never frees a slot for a push in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      in_ready <= 1'b1;
    end else begin
      if (push) begin
        mem_a[wr_ptr] <= in_a;
        mem_b[wr_ptr] <= in_b;
        wr_ptr        <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count    <= count_next;
      in_ready <= (count_next != CW'(DEPTH));
    end
  end

`ifdef ADD_SEQ_COUT_EN
  logic [WIDTH:0] sum_ext;
  logic           carry;
  assign sum_ext = {1'b0, head_a} + {1'b0, head_b};
  assign carry   = |(sum_ext >> WIDTH);
`endif

  // Launch / wait / hold sequencer with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      wcnt      <= '0;
      add_en    <= 1'b0;
      res_valid <= 1'b0;
      res_sum   <= '0;
      busy      <= 1'b0;
`ifdef ADD_SEQ_COUT_EN
      res_cout  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (!empty) begin
            state  <= S_LAUNCH;
            add_en <= 1'b1;
            busy   <= 1'b1;
          end
        end
        S_LAUNCH: begin
          add_en <= 1'b0;
          wcnt   <= WCW'(LATENCY - 1);
          state  <= S_WAIT;
        end
        S_WAIT: begin
          wcnt <= wcnt - WCW'(1);
          // wcnt==1 marks the cycle LATENCY-1 after the launch cycle
          if (wcnt == WCW'(1)) begin
            res_sum   <= add_out;
`ifdef ADD_SEQ_COUT_EN
            res_cout  <= carry;
`endif
            res_valid <= 1'b1;
            state     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          add_en    <= 1'b0;
          res_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add_serial_seq.sv
// Directed bench for add_serial_seq: table of operand pairs plus hand-written
// backpressure, full+pop, mid-operation reset and LATENCY=2 sequences.
module tb_add_serial_seq;

  localparam int L  = 10;
  localparam int L2 = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, add_en, res_valid, res_ready, busy;
  logic [7:0] in_a, in_b, add_a, add_b, add_out, res_sum;
  logic       in_valid2, in_ready2, add_en2, res_valid2, res_ready2, busy2;
  logic [7:0] in_a2, in_b2, add_a2, add_b2, add_out2, res_sum2;
`ifdef ADD_SEQ_COUT_EN
  logic       res_cout, res_cout2;
`endif

  add_serial_seq #(.WIDTH(8), .LATENCY(L), .DEPTH(2)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .add_en(add_en), .add_a(add_a), .add_b(add_b),
    .add_out(add_out), .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum),
`ifdef ADD_SEQ_COUT_EN
    .res_cout(res_cout),
`endif
    .busy(busy));

  add_serial_seq #(.WIDTH(8), .LATENCY(L2), .DEPTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_a(in_a2), .in_b(in_b2), .add_en(add_en2), .add_a(add_a2), .add_b(add_b2),
    .add_out(add_out2), .res_valid(res_valid2), .res_ready(res_ready2),
    .res_sum(res_sum2),
`ifdef ADD_SEQ_COUT_EN
    .res_cout(res_cout2),
`endif
    .busy(busy2));

  always #5 clk = ~clk;

  // Adder models: correct sum only in the cycle the sequencer should sample.
  int         mcnt, mcnt2;
  logic [7:0] msum, msum2;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mcnt <= 0; mcnt2 <= 0; msum <= 8'h00; msum2 <= 8'h00;
    end else begin
      if (add_en) begin mcnt <= 1; msum <= add_a + add_b; end
      else if (mcnt != 0) mcnt <= mcnt + 1;
      if (add_en2) begin mcnt2 <= 1; msum2 <= add_a2 + add_b2; end
      else if (mcnt2 != 0) mcnt2 <= mcnt2 + 1;
    end
  end
  assign add_out  = (mcnt == L - 1)   ? msum  : ~msum;
  assign add_out2 = (mcnt2 == L2 - 1) ? msum2 : ~msum2;

  // Cycle counter and add_en pulse log.
  int cyc = 0;
  int pulses[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (add_en) pulses.push_back(cyc);

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  // Push one pair into an idle DUT and check launch latency, result, carry.
  task automatic run_vec(input vec_t v, input int idx);
    int n, m;
    chk($sformatf("v%0d in_ready", idx), 32'(in_ready), 32'd1);
    in_a = v.a; in_b = v.b; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    n = 1;
    while (!add_en && n < 40) begin tick; n++; end
    chk($sformatf("v%0d launch_delay", idx), 32'(n), 32'd2);
    tick;
    m = 1;
    chk($sformatf("v%0d add_en_width", idx), 32'(add_en), 32'd0);
    while (!res_valid && m < 60) begin tick; m++; end
    chk($sformatf("v%0d valid_delay", idx), 32'(m), 32'(L));
    chk($sformatf("v%0d res_sum", idx), 32'(res_sum), 32'(v.sum));
`ifdef ADD_SEQ_COUT_EN
    chk($sformatf("v%0d res_cout", idx), 32'(res_cout), 32'(v.cout));
`endif
    tick;
    chk($sformatf("v%0d valid_drop", idx), 32'(res_valid), 32'd0);
    chk($sformatf("v%0d busy_drop", idx), 32'(busy), 32'd0);
  endtask

  // Wait (bounded) for a result, check it, accept it.
  task automatic wait_result(input logic [7:0] s, input logic c, input string name);
    int m;
    m = 0;
    while (!res_valid && m < 60) begin tick; m++; end
    chk({name, " timeout"}, 32'(res_valid), 32'd1);
    chk({name, " sum"}, 32'(res_sum), 32'(s));
`ifdef ADD_SEQ_COUT_EN
    chk({name, " cout"}, 32'(res_cout), 32'(c));
`else
    if (c === 1'bx) n_err++;
`endif
    tick;
  endtask

  vec_t vecs[7];

  initial begin
    int n, m, seen;
    vecs[0] = '{a: 8'h12, b: 8'h34, sum: 8'h46, cout: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, sum: 8'h00, cout: 1'b1};
    vecs[2] = '{a: 8'h80, b: 8'h80, sum: 8'h00, cout: 1'b1};
    vecs[3] = '{a: 8'h7F, b: 8'h01, sum: 8'h80, cout: 1'b0};
    vecs[4] = '{a: 8'hFF, b: 8'hFF, sum: 8'hFE, cout: 1'b1};
    vecs[5] = '{a: 8'h00, b: 8'h00, sum: 8'h00, cout: 1'b0};
    vecs[6] = '{a: 8'hA5, b: 8'h5A, sum: 8'hFF, cout: 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00; res_ready = 1'b1;
    in_valid2 = 1'b0; in_a2 = 8'h00; in_b2 = 8'h00; res_ready2 = 1'b1;
    tick; tick;
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst add_en", 32'(add_en), 32'd0);
    chk("rst res_valid", 32'(res_valid), 32'd0);
    chk("rst res_sum", 32'(res_sum), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst add_a", 32'(add_a), 32'd0);
`ifdef ADD_SEQ_COUT_EN
    chk("rst res_cout", 32'(res_cout), 32'd0);
`endif
    rst = 1'b0;
    tick;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Backpressure: three pairs offered with res_ready low.
    pulses.delete();
    res_ready = 1'b0;
    in_valid = 1'b1; in_a = 8'h01; in_b = 8'h02; tick;
    in_a = 8'h10; in_b = 8'h20; tick;
    in_a = 8'hF0; in_b = 8'h20;
    chk("bp in_ready_full", 32'(in_ready), 32'd0);
    for (int i = 0; i < 30; i++) tick;
    chk("bp single_pulse", 32'(pulses.size()), 32'd1);
    chk("bp stall_valid", 32'(res_valid), 32'd1);
    chk("bp stall_busy", 32'(busy), 32'd1);
    chk("bp stall_in_ready", 32'(in_ready), 32'd0);
    chk("bp first_sum", 32'(res_sum), 32'h03);
    // Full plus pop: handshake and offer in the same cycle.
    res_ready = 1'b1;
    tick;
    chk("fp in_ready_after_pop", 32'(in_ready), 32'd1);
    chk("fp valid_drop", 32'(res_valid), 32'd0);
    tick;
    in_valid = 1'b0;
    chk("fp refull", 32'(in_ready), 32'd0);
    wait_result(8'h30, 1'b0, "bp r1");
    wait_result(8'h10, 1'b1, "bp r2");
    chk("bp sum_hold", 32'(res_sum), 32'h10);
    chk("bp pulse_count", 32'(pulses.size()), 32'd3);
    if (pulses.size() == 3)
      chk("bp pulse_spacing", 32'(pulses[2] - pulses[1]), 32'(L + 2));
    tick;
    chk("bp in_ready_empty", 32'(in_ready), 32'd1);

    // Reset three cycles into WAIT.
    in_valid = 1'b1; in_a = 8'h33; in_b = 8'h44; tick; in_valid = 1'b0;
    n = 0;
    while (!add_en && n < 40) begin tick; n++; end
    chk("mr launch", 32'(add_en), 32'd1);
    tick; tick; tick;
    rst = 1'b1;
    #1;
    chk("mr busy", 32'(busy), 32'd0);
    chk("mr add_en", 32'(add_en), 32'd0);
    chk("mr res_valid", 32'(res_valid), 32'd0);
    chk("mr res_sum", 32'(res_sum), 32'd0);
    chk("mr add_a", 32'(add_a), 32'd0);
    chk("mr add_b", 32'(add_b), 32'd0);
    chk("mr in_ready", 32'(in_ready), 32'd1);
    tick;
    rst = 1'b0;
    pulses.delete();
    seen = 0;
    for (int i = 0; i < 25; i++) begin tick; if (res_valid) seen++; end
    chk("mr no_result", 32'(seen), 32'd0);
    chk("mr no_launch", 32'(pulses.size()), 32'd0);
    run_vec('{a: 8'h05, b: 8'h06, sum: 8'h0B, cout: 1'b0}, 99);

    // LATENCY=2 instance.
    in_valid2 = 1'b1; in_a2 = 8'h21; in_b2 = 8'h43; tick; in_valid2 = 1'b0;
    n = 1;
    while (!add_en2 && n < 40) begin tick; n++; end
    chk("l2 launch_delay", 32'(n), 32'd2);
    m = 0;
    while (!res_valid2 && m < 40) begin tick; m++; end
    chk("l2 valid_delay", 32'(m), 32'(L2));
    chk("l2 res_sum", 32'(res_sum2), 32'h64);
`ifdef ADD_SEQ_COUT_EN
    chk("l2 res_cout", 32'(res_cout2), 32'd0);
`endif
    tick;
    chk("l2 valid_drop", 32'(res_valid2), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/add_serial_seq.md
# add_serial_seq

Operand sequencer that sits directly upstream of the 8-bit serial adder and feeds it. It buffers operand pairs from a valid/ready source and launches one addition at a time. It waits a fixed latency for the adder's shift result, captures it, and presents the sum downstream on a valid/ready port. Only one addition is in flight at any time.

## Interface
- `WIDTH`, 8: operand and result width; must match the adder.
- `LATENCY`, 10: cycles from the `add_en` pulse cycle to the cycle in which `add_out` is sampled; legal range 2..255.
- `DEPTH`, 2: input FIFO entries; power of two, at least 2.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operand pair offered.
- `in_ready`  out  1  FIFO can accept a pair.
- `in_a`  in  WIDTH  operand A.
- `in_b`  in  WIDTH  operand B.
- `add_en`  out  1  one-cycle start pulse to the adder.
- `add_a`  out  WIDTH  operand A to the adder.
- `add_b`  out  WIDTH  operand B to the adder.
- `add_out`  in  WIDTH  adder result.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `res_sum`  out  WIDTH  captured sum.
- `res_cout`  out  1  carry-out; present only with `ADD_SEQ_COUT_EN`.
- `busy`  out  1  high in every state other than IDLE.

## Operation
- The FIFO stores {a,b} pairs.
  - Push on `in_valid && in_ready`.
  - `in_ready = !full`; there is no same-cycle pass-through when full, even if a pop occurs in that cycle.
  - Pop happens only on result handshake `res_valid && res_ready`.
- `add_a`/`add_b` are driven from the FIFO head. They are 0 when the FIFO is empty.
- The head is stable from LAUNCH until its result is accepted.
- FSM:
  - IDLE: if FIFO is non-empty, go to LAUNCH.
  - LAUNCH: `add_en=1` for exactly this cycle; load `wcnt = LATENCY-1`; go to WAIT.
  - WAIT: decrement `wcnt`. When `wcnt==1`, register `res_sum <= add_out` and go to HOLD.
  - HOLD: `res_valid=1`. On `res_ready`, pop the FIFO and go to IDLE.
- `res_sum` holds its value after the handshake until the next capture.
- Arithmetic: with the macro, `res_cout = carry(head_a + head_b)` in WIDTH+1 bits. It is computed from the head and registered at the capture edge. `res_sum` is taken from the adder and is not recomputed.
- Reset:
  - Asynchronously clears FIFO pointers and count, FSM to IDLE, `wcnt`, `res_sum`, and `res_cout`.
  - All outputs read 0 except `in_ready=1`.
  - Reset mid-operation discards the in-flight and buffered pairs. No result is emitted for them.

## Timing
- Let the LAUNCH cycle be T.
- `add_out` is sampled on the rising edge ending cycle T+LATENCY-1.
- `res_valid` is first high in cycle T+LATENCY.
- Minimum spacing between consecutive `add_en` pulses is LATENCY+2 cycles: LAUNCH, LATENCY-1 WAIT cycles, ≥1 HOLD cycle, 1 IDLE cycle.
- Push to an empty FIFO at edge E: IDLE sees non-empty at cycle E+1, and LAUNCH is cycle E+2.
- Simultaneous push and pop: both occur and the count is unchanged.
- Pointers wrap modulo DEPTH.
- `res_ready` held low stalls the FSM in HOLD indefinitely. No new launch occurs while stalled.
- `in_valid` dropped while `in_ready` is low: the pair is not accepted, and no error is raised.

## Configuration
- `ADD_SEQ_COUT_EN` defined:
  - The `res_cout` port exists.
  - One extra flop, plus a WIDTH+1 adder on the head operands.
- `ADD_SEQ_COUT_EN` undefined:
  - The port and its logic are absent.
  - All other behaviour is identical.

## Test plan
- Reset with nothing in flight: push a=8'h12, b=8'h34 with `res_ready=1`, adder model returns 8'h46.
  - `add_en` pulses once, 2 cycles after the push.
  - `res_valid` rises LATENCY cycles after the pulse with `res_sum=8'h46`.
  - `res_cout=0` with the macro defined.
- Carry case: push a=8'hFF, b=8'h01, model returns 8'h00.
  - `res_sum=8'h00`.
  - `res_cout=1` with the macro defined.
- Backpressure:
  - Push 3 pairs back to back with `res_ready=0`: `in_ready` drops after 2 accepted pairs; only one `add_en` pulse occurs.
  - Raise `res_ready`: results emerge in order, pulses spaced LATENCY+2 apart.
- Full plus pop: FIFO full, result handshake and `in_valid` in the same cycle.
  - The pair is not accepted that cycle (`in_ready=0`).
  - `in_ready=1` next cycle; count ends at DEPTH-1+1 after the retry.
- Reset mid-WAIT: assert `rst` 3 cycles after `add_en`.
  - All outputs go to 0 immediately and `in_ready=1`.
  - No `res_valid` follows.
  - A fresh pair afterwards completes normally.
- LATENCY=2 build: `res_valid` is high 2 cycles after the `add_en` cycle with the sampled value.
